// File: rtl/instr_fetch_arbiter.sv
// Two-core arbiter in front of a shared combinational instruction ROM. Round-robin on contention;
// defining INSTR_FETCH_ARB_FIXED_PRIO_EN makes core 0 always win contention instead.
module instr_fetch_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rd,
  output logic              grant0,
  output logic              grant1,
  output logic              stall0,
  output logic              stall1,
  output logic [DATA_W-1:0] instr0,
  output logic [DATA_W-1:0] instr1,
  output logic              rvalid0,
  output logic              rvalid1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_C0   = 2'd1,
    ST_C1   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              prefer1;
  logic [DATA_W-1:0] instr0_q, instr0_d;
  logic [DATA_W-1:0] instr1_q, instr1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (grant0) begin
      state_d = ST_C0;
    end else if (grant1) begin
      state_d = ST_C1;
    end
  end

  // While reset is high state_q is already IDLE, so grants follow the IDLE rule.
  always_comb begin
`ifdef INSTR_FETCH_ARB_FIXED_PRIO_EN
    prefer1 = 1'b0;
`else
    prefer1 = (state_q == ST_C0);
`endif
    grant0   = req0 & ~(req1 & prefer1);
    grant1   = req1 & ~grant0;
    stall0   = req0 & ~grant0;
    stall1   = req1 & ~grant1;
    rom_addr = '0;
    if (grant0) begin
      rom_addr = addr0;
    end else if (grant1) begin
      rom_addr = addr1;
    end
  end

  always_comb begin
    instr0_d  = grant0 ? rom_rd : instr0_q;
    instr1_d  = grant1 ? rom_rd : instr1_q;
    rvalid0_d = grant0;
    rvalid1_d = grant1;
  end

  // Fetch result stage: one cycle after the grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr0_q  <= '0;
      instr1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      instr0_q  <= instr0_d;
      instr1_q  <= instr1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign instr0  = instr0_q;
  assign instr1  = instr1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_instr_fetch_arbiter.sv
// Bench for instr_fetch_arbiter: directed scenarios plus randomized traffic against a
// last-served-core reference model. Honours INSTR_FETCH_ARB_FIXED_PRIO_EN when defined.
module tb_instr_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic [31:0] rom_addr, rom_rd;
  logic        grant0, grant1, stall0, stall1;
  logic [31:0] instr0, instr1;
  logic        rvalid0, rvalid1;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          last_served;  // -1 none, 0 core 0, 1 core 1
  logic        eg0, eg1;
  logic [31:0] eaddr, cur_a0, cur_a1;
  logic [31:0] ei0, ei1;
  logic        ev0, ev1;

  instr_fetch_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .grant0(grant0), .grant1(grant1),
    .stall0(stall0), .stall1(stall1), .instr0(instr0), .instr1(instr1),
    .rvalid0(rvalid0), .rvalid1(rvalid1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h00A0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  always_comb rom_rd = rom_fn(rom_addr);

  // Drive one cycle of requests just after the falling edge and compute expected grants.
  task automatic apply(input logic r0, input logic r1, input logic [31:0] a0, input logic [31:0] a1);
    @(negedge clk);
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
    cur_a0 = a0; cur_a1 = a1;
    if (r0 && r1) begin
`ifdef INSTR_FETCH_ARB_FIXED_PRIO_EN
      eg0 = 1'b1;
`else
      eg0 = (last_served != 0);
`endif
      eg1 = ~eg0;
    end else begin
      eg0 = r0;
      eg1 = r1;
    end
    eaddr = eg0 ? a0 : (eg1 ? a1 : 32'h0);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      last_served = -1; ei0 = '0; ei1 = '0; ev0 = 1'b0; ev1 = 1'b0;
    end else begin
      ev0 = eg0; ev1 = eg1;
      if (eg0) ei0 = rom_fn(cur_a0);
      if (eg1) ei1 = rom_fn(cur_a1);
      last_served = eg0 ? 0 : (eg1 ? 1 : -1);
    end
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, 32'h100, 32'h200);
    n_checks++; if (grant0 !== 1'b1 || grant1 !== 1'b0) begin n_fail++; $display("FAIL reset_grant got g0=%b g1=%b want g0=1 g1=0", grant0, grant1); end
    n_checks++; if (rom_addr !== 32'h100) begin n_fail++; $display("FAIL reset_rom_addr got %h want 00000100", rom_addr); end
    n_checks++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL reset_stall1 got %b want 1", stall1); end
    n_checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || instr0 !== 32'h0 || instr1 !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs got rv=%b%b i0=%h i1=%h want 00 0 0", rvalid0, rvalid1, instr0, instr1); end
    tick();
    n_checks++; if (rvalid0 !== 1'b0 || instr0 !== 32'h0) begin n_fail++; $display("FAIL reset_hold got rv0=%b i0=%h want 0 0", rvalid0, instr0); end
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    tick();
    n_checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin n_fail++; $display("FAIL reset_release_rvalid got %b%b want 00", rvalid0, rvalid1); end
  endtask

  task automatic test_single_fetch();
    apply(1'b1, 1'b0, 32'h0000_0008, 32'h0000_0044);
    n_checks++; if (grant0 !== 1'b1 || grant1 !== 1'b0 || stall0 !== 1'b0) begin
      n_fail++; $display("FAIL single_grant got g0=%b g1=%b s0=%b want 1 0 0", grant0, grant1, stall0); end
    n_checks++; if (rom_addr !== 32'h0000_0008) begin n_fail++; $display("FAIL single_rom_addr got %h want 00000008", rom_addr); end
    tick();
    n_checks++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin n_fail++; $display("FAIL single_rvalid got %b%b want 10", rvalid0, rvalid1); end
    n_checks++; if (instr0 !== 32'h00A0_0093) begin n_fail++; $display("FAIL single_instr0 got %h want 00a00093", instr0); end
  endtask

  task automatic test_contention();
    logic [31:0] a0, a1;
    logic        w0;
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      a0 = 32'h1003 + 32'(i * 16);
      a1 = 32'h2001 + 32'(i * 16);
`ifdef INSTR_FETCH_ARB_FIXED_PRIO_EN
      w0 = 1'b1;
`else
      w0 = (i % 2 == 0);
`endif
      apply(1'b1, 1'b1, a0, a1);
      n_checks++; if (grant0 !== w0 || grant1 !== ~w0) begin n_fail++; $display("FAIL contend_grant[%0d] got g0=%b g1=%b want g0=%b", i, grant0, grant1, w0); end
      n_checks++; if (stall0 !== ~w0 || stall1 !== w0) begin n_fail++; $display("FAIL contend_stall[%0d] got s0=%b s1=%b want s1=%b", i, stall0, stall1, w0); end
      n_checks++; if (rom_addr !== (w0 ? a0 : a1)) begin n_fail++; $display("FAIL contend_rom_addr[%0d] got %h want %h", i, rom_addr, w0 ? a0 : a1); end
      tick();
      n_checks++; if (rvalid0 !== w0 || rvalid1 !== ~w0) begin n_fail++; $display("FAIL contend_rvalid[%0d] got %b%b want rv0=%b", i, rvalid0, rvalid1, w0); end
      n_checks++; if ((w0 ? instr0 : instr1) !== rom_fn(w0 ? a0 : a1)) begin
        n_fail++; $display("FAIL contend_instr[%0d] got %h want %h", i, w0 ? instr0 : instr1, rom_fn(w0 ? a0 : a1)); end
    end
  endtask

  task automatic test_req1_then_both();
    logic want1 [5];
    want1[0] = 1'b1; want1[1] = 1'b1; want1[2] = 1'b1; want1[3] = 1'b0;
`ifdef INSTR_FETCH_ARB_FIXED_PRIO_EN
    want1[4] = 1'b0;
`else
    want1[4] = 1'b1;
`endif
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply(i >= 3, 1'b1, 32'h300 + 32'(i), 32'h400 + 32'(i));
      n_checks++; if (grant1 !== want1[i] || grant0 !== (i >= 3 && !want1[i])) begin
        n_fail++; $display("FAIL r1both_grant[%0d] got g0=%b g1=%b want g1=%b", i, grant0, grant1, want1[i]); end
      tick();
      n_checks++; if (rvalid1 !== want1[i]) begin n_fail++; $display("FAIL r1both_rvalid1[%0d] got %b want %b", i, rvalid1, want1[i]); end
    end
  endtask

  task automatic test_idle();
    logic [31:0] h0, h1;
    apply(1'b1, 1'b0, 32'h0000_0500, 32'h0);
    tick();
    apply(1'b0, 1'b1, 32'h0, 32'h0000_0604);
    tick();
    h0 = rom_fn(32'h500);
    h1 = rom_fn(32'h604);
    apply(1'b0, 1'b0, $urandom, $urandom);
    n_checks++; if (rom_addr !== 32'h0 || grant0 !== 1'b0 || grant1 !== 1'b0 || stall0 !== 1'b0 || stall1 !== 1'b0) begin
      n_fail++; $display("FAIL idle_comb got addr=%h g=%b%b s=%b%b want 0 00 00", rom_addr, grant0, grant1, stall0, stall1); end
    tick();
    n_checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid got %b%b want 00", rvalid0, rvalid1); end
    n_checks++; if (instr0 !== h0 || instr1 !== h1) begin n_fail++; $display("FAIL idle_instr_hold got %h %h want %h %h", instr0, instr1, h0, h1); end
  endtask

  task automatic test_reset_midop();
    apply(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    tick();
    n_checks++; if (rvalid0 !== 1'b1 || instr0 !== rom_fn(32'h20)) begin
      n_fail++; $display("FAIL midop_pre got rv0=%b i0=%h want 1 %h", rvalid0, instr0, rom_fn(32'h20)); end
    req0 = 1'b1; req1 = 1'b1; addr1 = 32'h0000_0024;
    reset = 1'b1;
    last_served = -1; ei0 = '0; ei1 = '0; ev0 = 1'b0; ev1 = 1'b0;
    #1;
    n_checks++; if (rvalid0 !== 1'b0 || instr0 !== 32'h0 || instr1 !== 32'h0) begin
      n_fail++; $display("FAIL midop_async got rv0=%b i0=%h i1=%h want 0 0 0", rvalid0, instr0, instr1); end
    n_checks++; if (grant0 !== 1'b1 || grant1 !== 1'b0) begin n_fail++; $display("FAIL midop_state_idle got g0=%b g1=%b want 1 0", grant0, grant1); end
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    tick();
    n_checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin n_fail++; $display("FAIL midop_no_rvalid got %b%b want 00", rvalid0, rvalid1); end
  endtask

  task automatic test_random();
    logic        r0 = 1'b0, r1 = 1'b0;
    logic [31:0] a0 = '0, a1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(r0 && !eg0) || i == 0) begin r0 = ($urandom % 4) != 0; a0 = $urandom; end
      if (!(r1 && !eg1) || i == 0) begin r1 = ($urandom % 4) != 0; a1 = $urandom; end
      apply(r0, r1, a0, a1);
      n_checks++; if (grant0 !== eg0 || grant1 !== eg1) begin n_fail++; $display("FAIL rand_grant[%0d] got %b%b want %b%b", i, grant0, grant1, eg0, eg1); end
      n_checks++; if (stall0 !== (r0 & ~eg0) || stall1 !== (r1 & ~eg1)) begin
        n_fail++; $display("FAIL rand_stall[%0d] got %b%b want %b%b", i, stall0, stall1, r0 & ~eg0, r1 & ~eg1); end
      n_checks++; if (rom_addr !== eaddr) begin n_fail++; $display("FAIL rand_rom_addr[%0d] got %h want %h", i, rom_addr, eaddr); end
      tick();
      n_checks++; if (rvalid0 !== ev0 || rvalid1 !== ev1 || instr0 !== ei0 || instr1 !== ei1) begin
        n_fail++; $display("FAIL rand_regs[%0d] got rv=%b%b i0=%h i1=%h want rv=%b%b i0=%h i1=%h", i, rvalid0, rvalid1, instr0, instr1, ev0, ev1, ei0, ei1); end
    end
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    last_served = -1; eg0 = 1'b0; eg1 = 1'b0; eaddr = '0; cur_a0 = '0; cur_a1 = '0;
    ei0 = '0; ei1 = '0; ev0 = 1'b0; ev1 = 1'b0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_req1_then_both();
    test_idle();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch_arbiter.md
INSTR_FETCH_ARBITER -- requirements
Module: instr_fetch_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, fetch address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0 / req1  input  1  fetch request from core 0 / core 1.
REQ-006 SHALL have ports addr0 / addr1  input  ADDR_W  byte fetch address from core 0 / core 1.
REQ-007 SHALL have port rom_addr  output  ADDR_W  address driven to the shared instruction ROM.
REQ-008 SHALL have port rom_rd  input  DATA_W  combinational ROM read data for rom_addr.
REQ-009 SHALL have ports grant0 / grant1  output  1  combinational same-cycle grant.
REQ-010 SHALL have ports stall0 / stall1  output  1  req_i and not grant_i.
REQ-011 SHALL have ports instr0 / instr1  output  DATA_W  registered instruction per core.
REQ-012 SHALL have ports rvalid0 / rvalid1  output  1  instr_i valid for one cycle.

Function
REQ-013 SHALL hold a registered FSM owner state in {IDLE, C0, C1}, recording the core served in the previous cycle.
REQ-014 SHALL grant at most one core per cycle; grant0 and grant1 never both high.
REQ-015 SHALL, with only req0 high, assert grant0; with only req1 high, assert grant1; neither high, no grant.
REQ-016 SHALL, with req0 and req1 both high, grant core 1 if state is C0, else core 0 (IDLE and C1 favour core 0).
REQ-017 SHALL drive rom_addr = addr0 when grant0, addr1 when grant1, all-zero when no grant.
REQ-018 SHALL pass the address unmodified, including bits [1:0]; word indexing is the ROM's job.
REQ-019 SHALL on each rising clk edge: state <= C0 if grant0, C1 if grant1, IDLE if no grant.
REQ-020 SHALL on rising edge with grant_i: instr_i <= rom_rd, rvalid_i <= 1; without grant_i: rvalid_i <= 0, instr_i holds.
REQ-021 SHALL give one-cycle fetch latency: request granted in cycle N yields rvalid_i in cycle N+1.
REQ-022 SHALL keep stall_i combinational so a stalled core holds its address and request into the next cycle.
REQ-023 SHALL bound wait under continuous contention to one cycle per core (strict alternation 0,1,0,1...).
REQ-024 SHALL ignore addr_i when req_i is low.

Reset
REQ-025 SHALL on reset asynchronously force state = IDLE, rvalid0 = rvalid1 = 0, instr0 = instr1 = 0.
REQ-026 SHALL drive grants, stalls and rom_addr combinationally during reset as if state = IDLE; registers stay at reset values while reset is high.
REQ-027 SHALL discard any fetch in flight when reset asserts mid-operation; no rvalid follows reset deassertion without a new grant.

Configuration
REQ-028 SHALL with macro INSTR_FETCH_ARB_FIXED_PRIO_EN defined use fixed priority: core 0 always wins contention, ignoring state.
REQ-029 SHALL without INSTR_FETCH_ARB_FIXED_PRIO_EN use the round-robin rule of REQ-016; all other behaviour identical.

Verification
REQ-030 SHALL cover: after reset, req0=1 addr0=0x00000008, rom_rd=0x00A00093 -> grant0=1 same cycle, rom_addr=0x00000008, next cycle rvalid0=1 instr0=0x00A00093.
REQ-031 SHALL cover: req0=req1=1 held 4 cycles from IDLE -> grants 0,1,0,1; stall1,stall0,stall1,stall0; rvalid alternates one cycle later.
REQ-032 SHALL cover: req1 alone 3 cycles, then both -> grant1 x3, then grant0 (state C1), then grant1.
REQ-033 SHALL cover: reset pulsed high in the cycle after grant0 -> rvalid0 and instr0 drop to 0 immediately; state IDLE; no rvalid after release.
REQ-034 SHALL cover: no requests -> rom_addr=0, both grants 0, both rvalid 0 next cycle, instr registers unchanged.
REQ-035 SHALL cover: INSTR_FETCH_ARB_FIXED_PRIO_EN defined, req0=req1=1 for 3 cycles -> grant0 every cycle, stall1 held high.
